// File: rtl/epcs_flash_responder.sv
// epcs_flash_responder
//
// Slave end of an EPCS serial-flash link, as driven by the Qsys EPCS flash
// controller. It decodes the read-class commands READ (0x03), RDSR (0x05) and
// RES (0xAB), and serves READ data from a generic byte-wide memory read port.
// All logic runs on clk_clk. The EPCS pins are oversampled, so clk_clk must
// run at least 8x faster than iDclk.
//
// Optional feature macro: EPCS_RESP_FAST_READ_EN
//   When defined, FAST_READ (0x0B) is decoded as address, then one dummy
//   byte, then data.
//   When undefined, 0x0B is treated like any other unknown command.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   iDclk          EPCS serial clock from the master (asynchronous)
//   iSce           chip select, active low (asynchronous)
//   iSdi           master-to-flash serial data (asynchronous)
//   oData0         flash-to-master serial data
//   oData0_oe      pad output enable for oData0
//   oMem_addr      byte read address
//   oMem_rd        one-cycle read strobe
//   iMem_rdata     read data
//   iMem_valid     read data valid, at most 2 clk after oMem_rd
//   oUnderrun      sticky: a data byte was needed before it had arrived
//   oCmd           last decoded command byte (debug)

module epcs_flash_responder #(
  parameter int         ADDR_W     = 24,
  parameter logic [7:0] SILICON_ID = 8'h14,
  parameter logic [7:0] STATUS_VAL = 8'h00
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              iDclk,
  input  logic              iSce,
  input  logic              iSdi,
  output logic              oData0,
  output logic              oData0_oe,
  output logic [ADDR_W-1:0] oMem_addr,
  output logic              oMem_rd,
  input  logic [7:0]        iMem_rdata,
  input  logic              iMem_valid,
  output logic              oUnderrun,
  output logic [7:0]        oCmd
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, STATUS, ID, IGNORE} stateT;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RES  = 8'hAB;
`ifdef EPCS_RESP_FAST_READ_EN
  localparam logic [7:0] CMD_FAST = 8'h0B;
`endif

  stateT       state, nextState;
  logic [1:0]  dclkSync, sceSync, sdiSync;
  logic        dclkHist, sceHist, sdiHist;
  logic [4:0]  bitCnt;
  logic [22:0] shiftIn;
  logic [23:0] rxWord;
  logic [2:0]  outBit;
  logic [7:0]  outShift;
  logic [7:0]  bufByte;
  logic        bufValid;
  logic [1:0]  pendCnt, dropCnt, pendAfter;
  logic [7:0]  byteOut;
  logic [4:0]  dummyLast;
  logic        deselect, rise, fall;
  logic        cmdDone, addrDone, dummyDone, firstRd, boundary, prefetch;
  logic        memAccept, memUse, underrunNow;
`ifdef EPCS_RESP_FAST_READ_EN
  logic        fastRead;
`endif

  // The chip is released as soon as the synchronized sce sample goes high.
  // A frame starts only once the history sample agrees that sce is low.
  // Data is taken from the history stage, which holds the value present
  // just before the detected dclk rise.
  assign deselect = sceSync[1] | sceHist;
  assign rise     = dclkSync[1] & ~dclkHist & ~deselect;
  assign fall     = ~dclkSync[1] & dclkHist & ~deselect;
  assign rxWord   = {shiftIn, sdiHist};

`ifdef EPCS_RESP_FAST_READ_EN
  assign dummyLast = fastRead ? 5'd7 : 5'd23;
`else
  assign dummyLast = 5'd23;
`endif

  // Reads return in order. Returns queued behind an underrun belong to a
  // byte that was already replaced by 0xFF, so they are dropped. This keeps
  // the address sequence aligned with the bytes that go out.
  assign memAccept   = iMem_valid && (pendCnt != 2'd0);
  assign memUse      = memAccept && (dropCnt == 2'd0);
  assign pendAfter   = pendCnt - 2'(memAccept);
  assign underrunNow = prefetch && !bufValid && !memUse;

  // Select the byte that starts at the next byte boundary.
  always_comb begin
    byteOut = 8'hFF;
    case (state)
      STATUS:  byteOut = STATUS_VAL;
      ID:      byteOut = SILICON_ID;
      default: begin
        if (bufValid)    byteOut = bufByte;
        else if (memUse) byteOut = iMem_rdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= nextState;
  end

  // Next-state decode and the per-cycle control strobes.
  always_comb begin
    nextState = state;
    cmdDone   = 1'b0;
    addrDone  = 1'b0;
    dummyDone = 1'b0;
    firstRd   = 1'b0;
    boundary  = 1'b0;
    prefetch  = 1'b0;
    case (state)
      IDLE: nextState = CMD;
      CMD: if (rise && bitCnt == 5'd7) begin
        cmdDone = 1'b1;
        case (rxWord[7:0])
          CMD_READ: nextState = ADDR;
          CMD_RDSR: nextState = STATUS;
          CMD_RES:  nextState = DUMMY;
`ifdef EPCS_RESP_FAST_READ_EN
          CMD_FAST: nextState = ADDR;
`endif
          default:  nextState = IGNORE;
        endcase
      end
      ADDR: if (rise && bitCnt == 5'd23) begin
        addrDone = 1'b1;
`ifdef EPCS_RESP_FAST_READ_EN
        if (fastRead) nextState = DUMMY;
        else begin
          nextState = DATA;
          firstRd   = 1'b1;
        end
`else
        nextState = DATA;
        firstRd   = 1'b1;
`endif
      end
      DUMMY: if (rise && bitCnt == dummyLast) begin
        dummyDone = 1'b1;
`ifdef EPCS_RESP_FAST_READ_EN
        if (fastRead) begin
          nextState = DATA;
          firstRd   = 1'b1;
        end else nextState = ID;
`else
        nextState = ID;
`endif
      end
      DATA, STATUS, ID: if (fall && outBit == 3'd0) begin
        boundary = 1'b1;
        prefetch = (state == DATA);
      end
      default: ;
    endcase
    if (deselect) nextState = IDLE;
  end

  // Pin synchronizers, shifters, the read buffer and the registered outputs.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      dclkSync  <= 2'b00;
      dclkHist  <= 1'b0;
      sceSync   <= 2'b11;
      sceHist   <= 1'b1;
      sdiSync   <= 2'b00;
      sdiHist   <= 1'b0;
      bitCnt    <= '0;
      shiftIn   <= '0;
      outBit    <= '0;
      outShift  <= '0;
      bufByte   <= '0;
      bufValid  <= 1'b0;
      pendCnt   <= '0;
      dropCnt   <= '0;
      oData0    <= 1'b0;
      oData0_oe <= 1'b0;
      oMem_addr <= '0;
      oMem_rd   <= 1'b0;
      oUnderrun <= 1'b0;
      oCmd      <= 8'h00;
`ifdef EPCS_RESP_FAST_READ_EN
      fastRead  <= 1'b0;
`endif
    end else begin
      dclkSync  <= {dclkSync[0], iDclk};
      dclkHist  <= dclkSync[1];
      sceSync   <= {sceSync[0], iSce};
      sceHist   <= sceSync[1];
      sdiSync   <= {sdiSync[0], iSdi};
      sdiHist   <= sdiSync[1];
      oMem_rd   <= firstRd | prefetch;
      oData0_oe <= (nextState == DATA) || (nextState == STATUS) || (nextState == ID);
      if (nextState == IDLE) begin
        bitCnt   <= '0;
        outBit   <= '0;
        bufValid <= 1'b0;
        pendCnt  <= '0;
        dropCnt  <= '0;
        oData0   <= 1'b0;
      end else begin
        if (rise && (state == CMD || state == ADDR || state == DUMMY)) begin
          shiftIn <= rxWord[22:0];
          bitCnt  <= bitCnt + 5'd1;
        end
        if (cmdDone || addrDone || dummyDone) bitCnt <= '0;
        if (cmdDone) begin
          oCmd <= rxWord[7:0];
`ifdef EPCS_RESP_FAST_READ_EN
          fastRead <= (rxWord[7:0] == CMD_FAST);
`endif
        end
        if (addrDone)      oMem_addr <= rxWord[ADDR_W-1:0];
        else if (prefetch) oMem_addr <= oMem_addr + ADDR_W'(1);
        pendCnt <= pendCnt - 2'(memAccept) + 2'(firstRd | prefetch);
        dropCnt <= dropCnt - 2'(memAccept && dropCnt != 2'd0)
                           + 2'(underrunNow && pendAfter != 2'd0);
        if (boundary)    bufValid <= bufValid && memUse;
        else if (memUse) bufValid <= 1'b1;
        if (memUse) bufByte <= iMem_rdata;
        if (fall && (state == DATA || state == STATUS || state == ID)) begin
          outBit <= outBit + 3'd1;
          if (outBit == 3'd0) begin
            oData0   <= byteOut[7];
            outShift <= {byteOut[6:0], 1'b0};
          end else begin
            oData0   <= outShift[7];
            outShift <= {outShift[6:0], 1'b0};
          end
        end
        if (underrunNow) oUnderrun <= 1'b1;
      end
    end
  end

endmodule
